asrv32_writeback_pipe: RTL and testbench

Parametrised, registered writeback stage for the pipelined ASRV32 core, sitting after the memory-access stage and feeding the base register file and fetch. It aligns and sign-extends load data, waits on a data-memory acknowledge (stalling the pipeline), and selects the rd source. It also redirects the PC on trap entry and MRET, holding a multi-cycle flush. It supports XLEN 32/64 and reduced register files (RV32E).

---
 rtl/asrv32_writeback_pipe_pkg.sv | 33 +++
 rtl/asrv32_writeback_pipe_load_align.sv | 43 ++++
 rtl/asrv32_writeback_pipe.sv | 164 ++++++++++++++++
 tb/tb_asrv32_writeback_pipe.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asrv32_writeback_pipe_pkg.sv
// ASRV32 writeback stage: shared opcode indices, load encodings
// and FSM state type.
package asrv32_writeback_pipe_pkg;

  localparam int OPCODE_WIDTH = 11;

  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LOAD   = 2;
  localparam int OP_STORE  = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 6;
  localparam int OP_LUI    = 7;
  localparam int OP_AUIPC  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int OP_FENCE  = 10;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_FLUSH     = 2'd2
  } wb_state_t;

endpackage

// File: rtl/asrv32_writeback_pipe_load_align.sv
// Load data alignment: picks byte/half/word at the load address
// and sign- or zero-extends it to XLEN.
module asrv32_load_align
  import asrv32_writeback_pipe_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int AW   = $clog2(XLEN/8)
) (
  input  logic [2:0]      funct3,
  input  logic [AW-1:0]   addr_lo,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] aligned
);

  logic [AW-1:0] h_off;
  logic [AW-1:0] w_off;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [31:0]   w;

  assign h_off = addr_lo & ~AW'(1);
  assign w_off = addr_lo & ~AW'(3);
  assign b = data[{addr_lo, 3'b000} +: 8];
  assign h = data[{h_off, 3'b000} +: 16];
  assign w = data[{w_off, 3'b000} +: 32];

  // LD and LWU only exist on RV64; on RV32 they fall back to LW
  always_comb begin
    aligned = XLEN'($signed(w));
    case (funct3)
      F3_LB:   aligned = XLEN'($signed(b));
      F3_LBU:  aligned = XLEN'(b);
      F3_LH:   aligned = XLEN'($signed(h));
      F3_LHU:  aligned = XLEN'(h);
      F3_LWU:  aligned = (XLEN == 64) ? XLEN'(w)
                                      : XLEN'($signed(w));
      F3_LD:   aligned = (XLEN == 64) ? data
                                      : XLEN'($signed(w));
      default: aligned = XLEN'($signed(w));
    endcase
  end

endmodule

// File: rtl/asrv32_writeback_pipe.sv
// ASRV32 writeback stage: rd select/write, load wait stall and
// PC redirect with multi-cycle flush on trap entry and MRET.
module asrv32_writeback_pipe
  import asrv32_writeback_pipe_pkg::*;
#(
  parameter  int              XLEN         = 32,
  parameter  int              REG_ADDR_W   = 5,
  parameter  logic [XLEN-1:0] PC_RESET     = '0,
  parameter  int              FLUSH_CYCLES = 1,
  localparam int              AW = $clog2(XLEN/8)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ce,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]              i_funct3,
  input  logic                    i_wr_rd_en,
  input  logic [REG_ADDR_W-1:0]   i_rd_addr,
  input  logic [XLEN-1:0]         i_rd_data,
  input  logic [XLEN-1:0]         i_load_data,
  input  logic                    i_load_ack,
  input  logic [AW-1:0]           i_addr_lo,
  input  logic [XLEN-1:0]         i_csr_data,
  input  logic                    i_go_to_trap,
  input  logic                    i_return_from_trap,
  input  logic [XLEN-1:0]         i_trap_address,
  input  logic [XLEN-1:0]         i_return_address,
  output logic                    o_wr_rd_en,
  output logic [REG_ADDR_W-1:0]   o_rd_addr,
  output logic [XLEN-1:0]         o_rd_data,
  output logic [XLEN-1:0]         o_next_pc,
  output logic                    o_change_pc,
  output logic                    o_stall,
  output logic                    o_flush
);

  wb_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [REG_ADDR_W-1:0] p_rd;
  logic [2:0]            p_f3;
  logic [AW-1:0]         p_lo;
  logic                  p_we;

  logic            accept, waiting, trap;
  logic            is_load, is_csr, we_req;
  logic [2:0]      al_f3;
  logic [AW-1:0]   al_lo;
  logic [XLEN-1:0] al_data;

  logic                  we_nxt, chg_nxt;
  logic [REG_ADDR_W-1:0] rd_nxt;
  logic [XLEN-1:0]       data_nxt, pc_nxt;

  assign accept  = (state == ST_RUN) && i_ce;
  assign waiting = (state == ST_WAIT_LOAD);
  assign trap    = i_go_to_trap || i_return_from_trap;
  assign is_load = i_opcode[OP_LOAD];
  assign is_csr  = i_opcode[OP_SYSTEM] && (i_funct3 != 3'd0);
  assign we_req  = i_wr_rd_en
                && !i_opcode[OP_BRANCH]
                && !i_opcode[OP_STORE]
                && !(i_opcode[OP_SYSTEM] && i_funct3 == 3'd0)
                && (i_rd_addr != '0);

  // while waiting, alignment must follow the latched load
  assign al_f3 = waiting ? p_f3 : i_funct3;
  assign al_lo = waiting ? p_lo : i_addr_lo;

  assign o_stall = (waiting && !i_load_ack)
                || (accept && is_load && !i_load_ack);

  asrv32_load_align #(.XLEN(XLEN)) u_align (
    .funct3  (al_f3),
    .addr_lo (al_lo),
    .data    (i_load_data),
    .aligned (al_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RUN: begin
        if (accept && trap) begin
          state_nxt = ST_FLUSH;
          cnt_nxt   = 4'(FLUSH_CYCLES - 1);
        end else if (accept && is_load && !i_load_ack) begin
          state_nxt = ST_WAIT_LOAD;
        end
      end
      ST_WAIT_LOAD: begin
        if (i_load_ack) state_nxt = ST_RUN;
      end
      ST_FLUSH: begin
        if (cnt == '0) state_nxt = ST_RUN;
        else           cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    we_nxt   = 1'b0;
    chg_nxt  = 1'b0;
    rd_nxt   = o_rd_addr;
    data_nxt = o_rd_data;
    pc_nxt   = o_next_pc;
    if (accept && trap) begin
      chg_nxt = 1'b1;
      pc_nxt  = i_go_to_trap ? i_trap_address
                             : i_return_address;
    end else if (accept && (!is_load || i_load_ack)) begin
      we_nxt   = we_req;
      rd_nxt   = i_rd_addr;
      data_nxt = is_load ? al_data
               : is_csr  ? i_csr_data
               : i_rd_data;
    end else if (waiting && i_load_ack) begin
      we_nxt   = p_we;
      rd_nxt   = p_rd;
      data_nxt = al_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wr_rd_en  <= 1'b0;
      o_rd_addr   <= '0;
      o_rd_data   <= '0;
      o_next_pc   <= PC_RESET;
      o_change_pc <= 1'b0;
      o_flush     <= 1'b0;
      p_rd        <= '0;
      p_f3        <= '0;
      p_lo        <= '0;
      p_we        <= 1'b0;
    end else begin
      o_wr_rd_en  <= we_nxt;
      o_rd_addr   <= rd_nxt;
      o_rd_data   <= data_nxt;
      o_next_pc   <= pc_nxt;
      o_change_pc <= chg_nxt;
      o_flush     <= (state_nxt == ST_FLUSH);
      if (accept && !trap && is_load && !i_load_ack) begin
        p_rd <= i_rd_addr;
        p_f3 <= i_funct3;
        p_lo <= i_addr_lo;
        p_we <= we_req;
      end
    end
  end

endmodule

// File: tb/tb_asrv32_writeback_pipe.sv
// Bench for asrv32_writeback_pipe: RV32 and RV64/RV32E instances
// driven in lockstep against a behavioural model.
module tb_asrv32_writeback_pipe;
  import asrv32_writeback_pipe_pkg::*;

  localparam logic [63:0] PCR32 = 64'h80;
  localparam logic [63:0] PCR64 = 64'h200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic [OPCODE_WIDTH-1:0] opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        wr_rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [63:0] rd_data = '0;
  logic [63:0] load_data = '0;
  logic [63:0] csr_data = '0;
  logic [63:0] trap_address = '0;
  logic [63:0] return_address = '0;
  logic        load_ack = 1'b0;
  logic [2:0]  addr_lo = '0;
  logic        go_to_trap = 1'b0;
  logic        return_from_trap = 1'b0;

  logic        a_we, a_chg, a_stall, a_flush;
  logic [4:0]  a_rd;
  logic [31:0] a_data, a_pc;
  logic        b_we, b_chg, b_stall, b_flush;
  logic [3:0]  b_rd;
  logic [63:0] b_data, b_pc;

  int checks = 0;
  int failures = 0;

  int          m_op;
  logic [2:0]  m_f3, m_lo;
  logic [4:0]  m_rd;
  logic        m_we;
  logic [63:0] m_rdd, m_csr, m_ld;

  always #5 clk = ~clk;

  asrv32_writeback_pipe #(
    .XLEN(32), .REG_ADDR_W(5),
    .PC_RESET(32'h80), .FLUSH_CYCLES(3)
  ) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
    .i_opcode(opcode), .i_funct3(funct3),
    .i_wr_rd_en(wr_rd_en), .i_rd_addr(rd_addr),
    .i_rd_data(rd_data[31:0]),
    .i_load_data(load_data[31:0]),
    .i_load_ack(load_ack), .i_addr_lo(addr_lo[1:0]),
    .i_csr_data(csr_data[31:0]),
    .i_go_to_trap(go_to_trap),
    .i_return_from_trap(return_from_trap),
    .i_trap_address(trap_address[31:0]),
    .i_return_address(return_address[31:0]),
    .o_wr_rd_en(a_we), .o_rd_addr(a_rd),
    .o_rd_data(a_data), .o_next_pc(a_pc),
    .o_change_pc(a_chg), .o_stall(a_stall),
    .o_flush(a_flush)
  );

  asrv32_writeback_pipe #(
    .XLEN(64), .REG_ADDR_W(4),
    .PC_RESET(64'h200), .FLUSH_CYCLES(2)
  ) u64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
    .i_opcode(opcode), .i_funct3(funct3),
    .i_wr_rd_en(wr_rd_en), .i_rd_addr(rd_addr[3:0]),
    .i_rd_data(rd_data), .i_load_data(load_data),
    .i_load_ack(load_ack), .i_addr_lo(addr_lo),
    .i_csr_data(csr_data),
    .i_go_to_trap(go_to_trap),
    .i_return_from_trap(return_from_trap),
    .i_trap_address(trap_address),
    .i_return_address(return_address),
    .o_wr_rd_en(b_we), .o_rd_addr(b_rd),
    .o_rd_data(b_data), .o_next_pc(b_pc),
    .o_change_pc(b_chg), .o_stall(b_stall),
    .o_flush(b_flush)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] align(
    int xlen, logic [2:0] f3,
    logic [2:0] lo, logic [63:0] d);
    logic [63:0] w, r;
    logic [7:0]  bb;
    logic [15:0] hh;
    logic [31:0] ww;
    int off;
    w   = (xlen == 32) ? {32'b0, d[31:0]} : d;
    off = (xlen == 32) ? int'(lo) % 4 : int'(lo);
    bb  = w[off*8 +: 8];
    hh  = w[(off/2)*16 +: 16];
    ww  = w[(off/4)*32 +: 32];
    case (f3)
      3'd0: r = {{56{bb[7]}}, bb};
      3'd4: r = {56'b0, bb};
      3'd1: r = {{48{hh[15]}}, hh};
      3'd5: r = {48'b0, hh};
      3'd3: r = (xlen == 64) ? w : {{32{ww[31]}}, ww};
      3'd6: r = (xlen == 64) ? {32'b0, ww}
                             : {{32{ww[31]}}, ww};
      default: r = {{32{ww[31]}}, ww};
    endcase
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [63:0] exp_data(int xlen);
    logic [63:0] r;
    if (m_op == OP_LOAD)
      r = align(xlen, m_f3, m_lo, m_ld);
    else if (m_op == OP_SYSTEM && m_f3 != 3'd0)
      r = m_csr;
    else
      r = m_rdd;
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic exp_we(int aw);
    logic nz;
    nz = (aw == 5) ? (m_rd != 5'd0) : (m_rd[3:0] != 4'd0);
    return m_we && nz
        && m_op != OP_BRANCH && m_op != OP_STORE
        && !(m_op == OP_SYSTEM && m_f3 == 3'd0);
  endfunction

  task automatic drive(int op, logic [2:0] f3,
                       logic [4:0] rd, logic we,
                       logic [63:0] rdd, logic [63:0] csr,
                       logic [63:0] ld, logic [2:0] lo,
                       logic ack);
    m_op = op;  m_f3 = f3;   m_rd = rd;  m_we = we;
    m_rdd = rdd; m_csr = csr; m_ld = ld; m_lo = lo;
    opcode = '0;
    opcode[op] = 1'b1;
    funct3 = f3; rd_addr = rd; wr_rd_en = we;
    rd_data = rdd; csr_data = csr; load_data = ld;
    addr_lo = lo; load_ack = ack;
    go_to_trap = 1'b0; return_from_trap = 1'b0;
    ce = 1'b1;
  endtask

  task automatic junk();
    ce = 1'b1;
    opcode = '0;
    opcode[$urandom_range(0, OPCODE_WIDTH-1)] = 1'b1;
    funct3 = 3'($urandom);
    addr_lo = 3'($urandom);
    rd_addr = 5'($urandom);
    wr_rd_en = 1'b1;
    go_to_trap = 1'($urandom);
    return_from_trap = 1'($urandom);
  endtask

  task automatic chk_done(string tag);
    logic e;
    e = exp_we(5);
    chk({tag, ".we32"}, 64'(a_we), 64'(e));
    if (e) begin
      chk({tag, ".rd32"}, 64'(a_rd), 64'(m_rd));
      chk({tag, ".data32"}, 64'(a_data), exp_data(32));
    end
    chk({tag, ".chg32"}, 64'(a_chg), 64'd0);
    e = exp_we(4);
    chk({tag, ".we64"}, 64'(b_we), 64'(e));
    if (e) begin
      chk({tag, ".rd64"}, 64'(b_rd), 64'(m_rd[3:0]));
      chk({tag, ".data64"}, b_data, exp_data(64));
    end
    chk({tag, ".chg64"}, 64'(b_chg), 64'd0);
  endtask

  task automatic finish_simple(string tag);
    @(negedge clk);
    chk_done(tag);
    ce = 1'b0;
  endtask

  task automatic finish_wait(string tag, int d,
                             logic [63:0] nd);
    #1;
    chk({tag, ".stall0"}, 64'({a_stall, b_stall}), 64'd3);
    for (int k = 1; k < d; k++) begin
      @(negedge clk);
      junk();
      chk({tag, ".wwe"}, 64'({a_we, b_we}), 64'd0);
      #1;
      chk({tag, ".stall"}, 64'({a_stall, b_stall}), 64'd3);
    end
    @(negedge clk);
    junk();
    chk({tag, ".wwe"}, 64'({a_we, b_we}), 64'd0);
    load_ack = 1'b1;
    load_data = nd;
    m_ld = nd;
    #1;
    chk({tag, ".ackstall"}, 64'({a_stall, b_stall}), 64'd0);
    @(negedge clk);
    load_ack = 1'b0;
    ce = 1'b0;
    go_to_trap = 1'b0;
    return_from_trap = 1'b0;
    chk_done(tag);
  endtask

  task automatic run_trap(string tag, logic gt, logic mr,
                          logic [63:0] ta, logic [63:0] ra);
    logic [63:0] pc;
    drive(OP_ITYPE, 3'd0, 5'd7, 1'b1,
          64'h55, 64'h0, 64'h0, 3'd0, 1'b1);
    go_to_trap = gt;
    return_from_trap = mr;
    trap_address = ta;
    return_address = ra;
    pc = gt ? ta : ra;
    @(negedge clk);
    chk({tag, ".chg"}, 64'({a_chg, b_chg}), 64'd3);
    chk({tag, ".pc32"}, 64'(a_pc), {32'b0, pc[31:0]});
    chk({tag, ".pc64"}, b_pc, pc);
    chk({tag, ".fl"}, 64'({a_flush, b_flush}), 64'd3);
    chk({tag, ".we"}, 64'({a_we, b_we}), 64'd0);
    junk();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk({tag, ".chgoff"}, 64'({a_chg, b_chg}), 64'd0);
      chk({tag, ".fl32"}, 64'(a_flush), 64'(k < 3));
      chk({tag, ".fl64"}, 64'(b_flush), 64'(k < 2));
      chk({tag, ".fwe"}, 64'({a_we, b_we}), 64'd0);
      chk({tag, ".hold"}, b_pc, pc);
      if (k == 1) junk();
      else begin
        ce = 1'b0;
        go_to_trap = 1'b0;
        return_from_trap = 1'b0;
      end
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, ".we"}, 64'({a_we, b_we}), 64'd0);
    chk({tag, ".rd32"}, 64'(a_rd), 64'd0);
    chk({tag, ".rd64"}, 64'(b_rd), 64'd0);
    chk({tag, ".d32"}, 64'(a_data), 64'd0);
    chk({tag, ".d64"}, b_data, 64'd0);
    chk({tag, ".pc32"}, 64'(a_pc), PCR32);
    chk({tag, ".pc64"}, b_pc, PCR64);
    chk({tag, ".ctl"},
        64'({a_chg, b_chg, a_flush, b_flush, a_stall, b_stall}),
        64'd0);
  endtask

  initial begin
    int op, d;
    logic [2:0] f3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    drive(OP_ITYPE, 3'd0, 5'd5, 1'b1, 64'h1234,
          64'h0, 64'h0, 3'd0, 1'b0);
    finish_simple("addi");
    drive(OP_ITYPE, 3'd0, 5'd0, 1'b1, 64'h1234,
          64'h0, 64'h0, 3'd0, 1'b0);
    finish_simple("addi_x0");
    drive(OP_LOAD, F3_LB, 5'd6, 1'b1, 64'h0, 64'h0,
          64'h0080_0000, 3'd2, 1'b1);
    finish_simple("lb");
    drive(OP_LOAD, F3_LBU, 5'd6, 1'b1, 64'h0, 64'h0,
          64'h0080_0000, 3'd2, 1'b1);
    finish_simple("lbu");
    drive(OP_LOAD, F3_LHU, 5'd9, 1'b1, 64'h0, 64'h0,
          64'hBEEF_0000, 3'd2, 1'b1);
    finish_simple("lhu");
    drive(OP_LOAD, F3_LWU, 5'd10, 1'b1, 64'h0, 64'h0,
          64'h0000_0000_8000_0000, 3'd0, 1'b1);
    finish_simple("lwu");
    drive(OP_LOAD, F3_LW, 5'd11, 1'b1, 64'h0, 64'h0,
          64'h0000_0000_8000_0000, 3'd0, 1'b1);
    finish_simple("lw");
    drive(OP_SYSTEM, 3'd2, 5'd12, 1'b1, 64'h11,
          64'hCAFE_F00D_1234_5678, 64'h0, 3'd0, 1'b1);
    finish_simple("csr");
    drive(OP_SYSTEM, 3'd0, 5'd12, 1'b1, 64'h11,
          64'h99, 64'h0, 3'd0, 1'b1);
    finish_simple("ecall");
    drive(OP_STORE, 3'd2, 5'd3, 1'b1, 64'h11,
          64'h0, 64'h0, 3'd0, 1'b1);
    finish_simple("store");
    drive(OP_BRANCH, 3'd0, 5'd3, 1'b1, 64'h11,
          64'h0, 64'h0, 3'd0, 1'b1);
    finish_simple("branch");

    drive(OP_LOAD, F3_LW, 5'd13, 1'b1, 64'h0, 64'h0,
          64'h0, 3'd4, 1'b0);
    finish_wait("lw_wait3", 3, 64'h8765_4321_DEAD_BEEF);

    run_trap("trap", 1'b1, 1'b1, 64'h100, 64'h200);
    run_trap("mret", 1'b0, 1'b1, 64'h100, 64'h3000);

    drive(OP_LOAD, F3_LW, 5'd14, 1'b1, 64'h0, 64'h0,
          64'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b0;
    load_ack = 1'b0;
    @(negedge clk);
    chk_reset("rst_wait");
    rst_n = 1'b1;
    load_ack = 1'b1;
    load_data = 64'h1234_5678;
    @(negedge clk);
    chk("rst_wait.nowrite", 64'({a_we, b_we}), 64'd0);
    chk_reset("rst_after");
    load_ack = 1'b0;

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        run_trap("rnd_trap", 1'($urandom), 1'b1,
                 {$urandom, $urandom}, {$urandom, $urandom});
      end else begin
        op = $urandom_range(0, OPCODE_WIDTH-1);
        if ($urandom_range(0, 2) == 0) op = OP_LOAD;
        f3 = (op == OP_LOAD) ? 3'($urandom_range(0, 6))
                             : 3'($urandom);
        d = (op == OP_LOAD) ? $urandom_range(0, 3) : 0;
        drive(op, f3, 5'($urandom), 1'($urandom_range(0, 7) != 0),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 3'($urandom), d == 0);
        if (d == 0) finish_simple("rnd");
        else finish_wait("rnd_wait", d, {$urandom, $urandom});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
